// File: rtl/ib_pkg.sv
// Shared types and bit positions for the MCU nibble-port transfer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ib_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PRES = 2'd1,
        R_ACK  = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PUSH = 2'd1,
        W_ACK  = 2'd2
    } wr_state_t;

    // Port 3 control nibble, written by the MCU
    localparam int CTL_MODE       = 0;
    localparam int CTL_RD_DONE_N  = 1;
    localparam int CTL_WR_AVAIL_N = 2;
    localparam int CTL_ERR_CLR_N  = 3;

    // Port 2 status nibble, read by the MCU
    localparam int ST_RD_RDY_N  = 0;
    localparam int ST_RX_PEND   = 1;
    localparam int ST_ERR       = 2;
    localparam int ST_WR_BUSY_N = 3;

    localparam logic [3:0] STATUS_RST = 4'b1001;

endpackage

// File: rtl/ib_hs_timer.sv
// Handshake stall timer: counts cycles while run=1 and flags expiry at TIMEOUT_CYC-1.
// Latency: expired is combinational from the count register; clr/!run zero it next cycle.
// Backpressure: none. Ports: clk, rst (sync, high), run, clr -> expired. TIMEOUT_CYC=0 disables.
module ib_hs_timer #(
    parameter int TIMEOUT_CYC = 800000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = (TIMEOUT_CYC > 0) ? W'(TIMEOUT_CYC - 1) : '0;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            // saturate so expired stays asserted until the owner leaves its state
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expired = (TIMEOUT_CYC != 0) && run && (cnt_q == LAST);

endmodule

// File: rtl/ib_xfer_ctrl.sv
// Byte transfer sequencer between UART RX/TX streams and the MCU nibble port expander.
// Latency: rx_valid -> status[0]=0 in 2 cycles; wr_avail_n=0 -> tx_valid in 1 cycle.
// Backpressure: tx_valid held until tx_ready; stalled MCU handshakes abort after TIMEOUT_CYC.
// Ports: clk, rst (sync, high); RX stream rx_valid/rx_data/rx_pop; TX stream tx_data/tx_valid/tx_ready;
//        expander ports: ctl_nib (port 3 in), wr_lo/wr_hi (ports 0/1 in), rd_lo/rd_hi (ports 0/1 out),
//        status (port 2 out).
module ib_xfer_ctrl
    import ib_pkg::*;
#(
    parameter int TIMEOUT_CYC = 800000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_pop,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [3:0] ctl_nib,
    input  logic [3:0] wr_lo,
    input  logic [3:0] wr_hi,
    output logic [3:0] rd_lo,
    output logic [3:0] rd_hi,
    output logic [3:0] status
);

    rd_state_t  rd_state_q;
    wr_state_t  wr_state_q;
    logic [3:0] rd_lo_q, rd_hi_q;
    logic       rx_pop_q;
    logic [7:0] tx_data_q;
    logic       tx_valid_q;
    logic       rd_rdy_n_q, rx_pend_q, err_q, wr_busy_n_q;

    logic both_idle, rd_start, wr_start;
    logic rd_run, rd_clr, rd_expired;
    logic wr_run, wr_clr, wr_expired;

    // Mode is only honoured while both sides are idle, so a mode flip
    // mid-transfer simply delays the other side until this one finishes.
    assign both_idle = (rd_state_q == R_IDLE) && (wr_state_q == W_IDLE);
    assign rd_start  = both_idle && !ctl_nib[CTL_MODE] && rx_valid && ctl_nib[CTL_RD_DONE_N];
    assign wr_start  = both_idle &&  ctl_nib[CTL_MODE] && !ctl_nib[CTL_WR_AVAIL_N];

    assign rd_run = (rd_state_q == R_PRES) || (rd_state_q == R_ACK);
    assign rd_clr = ((rd_state_q == R_PRES) && !ctl_nib[CTL_RD_DONE_N]) ||
                    ((rd_state_q == R_ACK)  &&  ctl_nib[CTL_RD_DONE_N]);
    assign wr_run = (wr_state_q == W_ACK);
    assign wr_clr = (wr_state_q == W_ACK) && ctl_nib[CTL_WR_AVAIL_N];

    ib_hs_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rd_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (rd_run),
        .clr     (rd_clr),
        .expired (rd_expired)
    );

    ib_hs_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wr_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (wr_run),
        .clr     (wr_clr),
        .expired (wr_expired)
    );

    // Read side: FPGA -> MCU. rx_pop pulses with the latch; the FIFO head
    // advances at the following edge, by which time the FSM sits in R_PRES.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_lo_q    <= '0;
            rd_hi_q    <= '0;
            rx_pop_q   <= 1'b0;
            rd_rdy_n_q <= STATUS_RST[ST_RD_RDY_N];
        end else begin
            rx_pop_q <= 1'b0;
            case (rd_state_q)
                R_IDLE: begin
                    if (rd_start) begin
                        rd_lo_q    <= rx_data[3:0];
                        rd_hi_q    <= rx_data[7:4];
                        rx_pop_q   <= 1'b1;
                        rd_state_q <= R_PRES;
                    end
                end
                R_PRES: begin
                    // timeout beats a same-cycle ack; the popped byte is lost
                    if (rd_expired) begin
                        rd_rdy_n_q <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end else if (!ctl_nib[CTL_RD_DONE_N]) begin
                        rd_rdy_n_q <= 1'b1;
                        rd_state_q <= R_ACK;
                    end else begin
                        rd_rdy_n_q <= 1'b0;
                    end
                end
                R_ACK: begin
                    if (rd_expired || ctl_nib[CTL_RD_DONE_N]) begin
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // Write side: MCU -> FPGA. W_ACK waits for wr_avail_n to rise again,
    // which is what prevents a second push while the MCU holds it low.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q  <= W_IDLE;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            wr_busy_n_q <= STATUS_RST[ST_WR_BUSY_N];
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (wr_start) begin
                        tx_data_q  <= {wr_hi, wr_lo};
                        tx_valid_q <= 1'b1;
                        wr_state_q <= W_PUSH;
                    end
                end
                W_PUSH: begin
                    if (tx_ready) begin
                        tx_valid_q  <= 1'b0;
                        wr_busy_n_q <= 1'b0;
                        wr_state_q  <= W_ACK;
                    end
                end
                W_ACK: begin
                    if (wr_expired || ctl_nib[CTL_WR_AVAIL_N]) begin
                        wr_busy_n_q <= 1'b1;
                        wr_state_q  <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Sticky error: a timeout in the same cycle as an error clear still sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_pend_q <= STATUS_RST[ST_RX_PEND];
            err_q     <= STATUS_RST[ST_ERR];
        end else begin
            rx_pend_q <= rx_valid;
            if (rd_expired || wr_expired) begin
                err_q <= 1'b1;
            end else if (!ctl_nib[CTL_ERR_CLR_N]) begin
                err_q <= 1'b0;
            end
        end
    end

    assign rx_pop   = rx_pop_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign rd_lo    = rd_lo_q;
    assign rd_hi    = rd_hi_q;
    assign status   = {wr_busy_n_q, err_q, rx_pend_q, rd_rdy_n_q};

endmodule

// File: tb/tb_ib_xfer_ctrl.sv
// Directed bench for ib_xfer_ctrl: read handshakes, write with backpressure,
// timeout and error clear, mode change mid-transfer, reset during a push.
module tb_ib_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_pop;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] ctl_nib;
    logic [3:0] wr_lo;
    logic [3:0] wr_hi;
    logic [3:0] rd_lo;
    logic [3:0] rd_hi;
    logic [3:0] status;

    int         checks   = 0;
    int         errors   = 0;
    int         pop_cnt  = 0;
    int         acc_cnt  = 0;
    logic [7:0] acc_last = 8'h00;
    int         n;
    logic [7:0] rd_bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    always #5 clk = ~clk;

    ib_xfer_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_pop   (rx_pop),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ctl_nib  (ctl_nib),
        .wr_lo    (wr_lo),
        .wr_hi    (wr_hi),
        .rd_lo    (rd_lo),
        .rd_hi    (rd_hi),
        .status   (status)
    );

    // Count FIFO pops and bytes actually accepted by the TX FIFO
    always @(posedge clk) begin
        if (rx_pop) pop_cnt++;
        if (tx_valid && tx_ready) begin
            acc_cnt++;
            acc_last = tx_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        ctl_nib  = 4'b1110;   // mode read, rd_done_n=1, wr_avail_n=1, err_clr_n=1
        wr_lo    = 4'h0;
        wr_hi    = 4'h0;
        tick;
        tick;
        chk("rst_rd_lo",    32'(rd_lo),    32'h0);
        chk("rst_rd_hi",    32'(rd_hi),    32'h0);
        chk("rst_status",   32'(status),   32'h9);
        chk("rst_rx_pop",   32'(rx_pop),   32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data",  32'(tx_data),  32'h00);
        rst = 1'b0;
        tick;

        // Read handshakes: DE, AD, BE, EF
        for (int i = 0; i < 4; i++) begin
            rx_data  = rd_bytes[i];
            rx_valid = 1'b1;
            tick;
            chk("rd_pop",        32'(rx_pop), 32'h1);
            chk("rd_lo",         32'(rd_lo),  32'(rd_bytes[i][3:0]));
            chk("rd_hi",         32'(rd_hi),  32'(rd_bytes[i][7:4]));
            chk("rd_status_lat", 32'(status), 32'hB);   // rx_pend=1, rd_rdy_n still 1
            rx_valid = 1'b0;
            tick;
            chk("rd_pop_once",   32'(rx_pop), 32'h0);
            chk("rd_status_rdy", 32'(status), 32'h8);   // rd_rdy_n=0 two cycles after rx_valid
            ctl_nib[1] = 1'b0;
            tick;
            chk("rd_status_ack", 32'(status), 32'h9);
            ctl_nib[1] = 1'b1;
            tick;
        end
        chk("rd_pop_count", 32'(pop_cnt), 32'd4);

        // Write with 20 cycles of backpressure
        ctl_nib = 4'b1111;
        wr_lo   = 4'h4;
        wr_hi   = 4'h4;
        tick;
        ctl_nib[2] = 1'b0;
        tick;
        chk("wr_valid_lat", 32'(tx_valid), 32'h1);
        chk("wr_data",      32'(tx_data),  32'h44);
        repeat (19) tick;
        chk("wr_valid_hold", 32'(tx_valid), 32'h1);
        chk("wr_data_hold",  32'(tx_data),  32'h44);
        chk("wr_status_bp",  32'(status),   32'h9);
        chk("wr_no_acc_bp",  32'(acc_cnt),  32'd0);
        tx_ready = 1'b1;
        tick;
        chk("wr_valid_drop", 32'(tx_valid), 32'h0);
        chk("wr_status_ack", 32'(status),   32'h1);
        chk("wr_acc_one",    32'(acc_cnt),  32'd1);
        chk("wr_acc_byte",   32'(acc_last), 32'h44);
        repeat (4) tick;
        chk("wr_no_dup_valid", 32'(tx_valid), 32'h0);
        ctl_nib[2] = 1'b1;
        tick;
        chk("wr_status_rest", 32'(status), 32'h9);
        tx_ready = 1'b0;
        tick;
        chk("wr_no_dup_acc", 32'(acc_cnt), 32'd1);

        // Timeout: byte presented, MCU never acks
        ctl_nib = 4'b1110;
        tick;
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        tick;
        chk("to_pop", 32'(rx_pop), 32'h1);
        rx_valid = 1'b0;
        n = 0;
        while (!status[2] && n < 40) begin
            tick;
            n++;
        end
        chk("to_cycles", 32'(n), 32'd16);
        // write side is idle, so wr_busy_n reads 1 alongside err and rd_rdy_n
        chk("to_status", 32'(status), 32'hD);
        chk("to_rd_lo",  32'(rd_lo),  32'hA);
        chk("to_rd_hi",  32'(rd_hi),  32'h5);
        ctl_nib[3] = 1'b0;
        tick;
        chk("err_clear", 32'(status), 32'h9);
        ctl_nib[3] = 1'b1;
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        tick;
        chk("to_idle_pop", 32'(rx_pop), 32'h1);
        chk("to_idle_lo",  32'(rd_lo),  32'hC);
        rx_valid = 1'b0;
        tick;
        ctl_nib[1] = 1'b0;
        tick;
        ctl_nib[1] = 1'b1;
        tick;

        // Mode flips to write while a read is presented
        rx_data  = 8'h77;
        wr_lo    = 4'h1;
        wr_hi    = 4'h2;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        tick;
        chk("mode_rd_pres", 32'(status[0]), 32'h0);
        ctl_nib = 4'b1011;   // mode write, wr_avail_n=0, rd_done_n still 1
        repeat (3) tick;
        chk("mode_wr_wait", 32'(tx_valid), 32'h0);
        ctl_nib[1] = 1'b0;
        tick;
        chk("mode_rd_ack",   32'(status[0]), 32'h1);
        chk("mode_wr_wait2", 32'(tx_valid),  32'h0);
        ctl_nib[1] = 1'b1;
        tick;
        chk("mode_wr_wait3", 32'(tx_valid), 32'h0);
        tick;
        chk("mode_wr_start", 32'(tx_valid), 32'h1);
        chk("mode_wr_data",  32'(tx_data),  32'h21);

        // Reset while in W_PUSH
        rst = 1'b1;
        tick;
        chk("rstp_tx_valid", 32'(tx_valid), 32'h0);
        chk("rstp_status",   32'(status),   32'h9);
        chk("rstp_tx_data",  32'(tx_data),  32'h00);
        chk("rstp_rd_lo",    32'(rd_lo),    32'h0);
        tx_ready = 1'b1;
        tick;
        rst      = 1'b0;
        ctl_nib  = 4'b1110;
        tx_ready = 1'b0;
        tick;
        chk("rstp_no_acc",  32'(acc_cnt),  32'd1);
        chk("rstp_valid2",  32'(tx_valid), 32'h0);
        chk("rstp_status2", 32'(status),   32'h9);
        chk("total_pops",   32'(pop_cnt),  32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
